// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search controller.
package sar_search_pkg;

  // Default operand width (and maximum number of compare steps).
  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_t;

endpackage

// File: rtl/sar_search_4bit_flag_check.sv
// Comparator flag sanity check: exactly one of gt/eq/lt may be set.
module sar_flag_check (
  input  logic gt,
  input  logic eq,
  input  logic lt,
  output logic onehot
);

  // XOR of three is 1 for one or three flags set; exclude the all-set case.
  assign onehot = (gt ^ eq ^ lt) & ~(gt & eq & lt);

endmodule

// File: rtl/sar_search_4bit.sv
// Successive-approximation search controller. Drives probe operands to an
// external magnitude comparator (target on A, probe on B), reads back the
// gt/eq/lt flags and resolves the target MSB first.
// Optional feature: define SAR_EARLY_EXIT_EN to end a search as soon as the
// comparator reports eq; otherwise every search runs WIDTH steps.
module sar_search_4bit
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       ready,
  output logic [WIDTH-1:0]           probe,
  output logic                       probe_valid,
  input  logic                       cmp_gt,
  input  logic                       cmp_eq,
  input  logic                       cmp_lt,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] steps
);

  localparam int SW = $clog2(WIDTH+1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  sar_state_t       state;
  logic [IW-1:0]    idx;
  logic             onehot;
  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] resolved;

  sar_flag_check u_flag_check (
    .gt     (cmp_gt),
    .eq     (cmp_eq),
    .lt     (cmp_lt),
    .onehot (onehot)
  );

  // Current trial bit and the probe with that bit decided by the flags.
  assign trial_bit = WIDTH'(1) << idx;
  assign resolved  = cmp_lt ? (probe & ~trial_bit) : probe;

  // Search FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      probe       <= '0;
      probe_valid <= 1'b0;
      ready       <= 1'b1;
      done        <= 1'b0;
      result      <= '0;
      err         <= 1'b0;
      steps       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SEARCH;
            ready       <= 1'b0;
            probe_valid <= 1'b1;
            probe       <= WIDTH'(1) << (WIDTH-1);
            idx         <= IW'(WIDTH-1);
            result      <= '0;
            err         <= 1'b0;
            steps       <= '0;
          end
        end

        SEARCH: begin
          steps <= steps + SW'(1);
          if (!onehot || (EARLY && cmp_eq) || (idx == '0)) begin
            // Search ends this cycle; the probe is withdrawn for DONE.
            state       <= DONE;
            probe_valid <= 1'b0;
            probe       <= '0;
            done        <= 1'b1;
            if (!onehot) begin
              err    <= 1'b1;
              result <= '0;
            end else if (EARLY && cmp_eq) begin
              result <= probe;
            end else begin
              result <= resolved;
            end
          end else begin
            // Keep/clear the trial bit and set the next lower one to try.
            probe <= resolved | (trial_bit >> 1);
            idx   <= idx - IW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          ready       <= 1'b1;
          probe_valid <= 1'b0;
          probe       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit: behavioural comparator, arithmetic model of the
// probe sequence / latency, per-cycle compare and directed scenarios.
module tb_sar_search_4bit;
  import sar_search_pkg::*;

  localparam int W  = SAR_WIDTH;
  localparam int SW = $clog2(W+1);
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          ready, probe_valid, done, err;
  logic [W-1:0]  probe, result;
  logic [SW-1:0] steps;
  logic          cmp_gt, cmp_eq, cmp_lt;

  logic [W-1:0]  target = '0;
  int            inj    = 0;   // 1-based sample index to corrupt, 0 = none
  int            pv_cnt = 0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  sar_search_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .probe(probe), .probe_valid(probe_valid),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .done(done), .result(result), .err(err), .steps(steps)
  );

  // Behavioural comparator with optional illegal-flag injection.
  logic bad;
  assign bad    = probe_valid && (inj != 0) && (pv_cnt + 1 == inj);
  assign cmp_gt = bad ? 1'b1 : (target > probe);
  assign cmp_eq = bad ? 1'b0 : (target == probe);
  assign cmp_lt = bad ? 1'b1 : (target < probe);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pv_cnt <= 0;
    else        pv_cnt <= probe_valid ? pv_cnt + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // k-th probe (0-based) for target t: target bits above the trial bit, trial bit set.
  function automatic logic [W-1:0] exp_probe(input logic [W-1:0] t, input int k);
    int b;
    logic [W-1:0] hi;
    b  = W - 1 - k;
    hi = (t >> (b + 1)) << (b + 1);
    return hi | (W'(1) << b);
  endfunction

  // Number of compare cycles for target t with injection at step i.
  function automatic int exp_len(input logic [W-1:0] t, input int i);
    int n;
    n = W;
    if (EARLY)
      for (int k = W - 1; k >= 0; k--)
        if (exp_probe(t, k) == t) n = k + 1;
    if (i != 0 && i <= n) n = i;
    return n;
  endfunction

  // Model: tracks accepted searches by edge number.
  int           edge_no = 0, e0 = 0, m_n = 0;
  bit           m_busy = 0;
  logic [W-1:0] m_tgt = '0, m_res = '0, f_res = '0;
  bit           m_err = 0, f_err = 0;
  int           m_steps = 0, f_steps = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_res = '0; m_err = 0; m_steps = 0;
    end else begin
      edge_no++;
      if (m_busy && (edge_no - e0 == m_n + 1)) begin
        m_busy = 0; m_res = f_res; m_err = f_err; m_steps = f_steps;
      end else if (!m_busy && start) begin
        m_busy  = 1; e0 = edge_no; m_tgt = target;
        m_n     = exp_len(target, inj);
        f_steps = m_n;
        if (inj != 0 && inj <= m_n) begin f_res = '0; f_err = 1; end
        else begin f_res = target; f_err = 0; end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  int r;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", ready, 1); chk("rst_pv", probe_valid, 0);
      chk("rst_probe", probe, 0); chk("rst_done", done, 0);
      chk("rst_result", result, 0); chk("rst_err", err, 0);
      chk("rst_steps", steps, 0);
    end else if (m_busy) begin
      r = edge_no - e0 + 1;
      if (r <= m_n) begin
        chk("srch_ready", ready, 0); chk("srch_pv", probe_valid, 1);
        chk("srch_done", done, 0);
        chk("srch_probe", probe, exp_probe(m_tgt, r - 1));
      end else begin
        chk("done_ready", ready, 0); chk("done_pv", probe_valid, 0);
        chk("done_pulse", done, 1); chk("done_probe", probe, 0);
        chk("done_result", result, f_res); chk("done_err", err, f_err);
        chk("done_steps", steps, f_steps);
      end
    end else begin
      chk("idle_ready", ready, 1); chk("idle_pv", probe_valid, 0);
      chk("idle_done", done, 0); chk("idle_probe", probe, 0);
      chk("idle_result", result, m_res); chk("idle_err", err, m_err);
      chk("idle_steps", steps, m_steps);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < 20);
    if (!ready) chk("wait_ready_timeout", ready, 1);
  endtask

  task automatic run(input logic [W-1:0] t, input int inj_s, input int e_cyc,
                     input int e_res, input int e_err, input int e_steps, input string tag);
    int cnt;
    wait_ready();
    @(negedge clk); target = t; inj = inj_s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!done && cnt < 20);
    chk({tag, "_done_cycle"}, cnt, e_cyc);
    chk({tag, "_result"}, result, e_res);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_steps"}, steps, e_steps);
    @(negedge clk);
    chk({tag, "_ready_after"}, ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    // Hand values pinning the model.
    chk("pin_p11_0", exp_probe(4'd11, 0), 8);
    chk("pin_p11_1", exp_probe(4'd11, 1), 12);
    chk("pin_p11_2", exp_probe(4'd11, 2), 10);
    chk("pin_p11_3", exp_probe(4'd11, 3), 11);
    chk("pin_p0_3",  exp_probe(4'd0, 3), 1);
    chk("pin_p15_2", exp_probe(4'd15, 2), 14);
    chk("pin_len8",  exp_len(4'd8, 0), EARLY ? 1 : 4);
    chk("pin_len11_inj2", exp_len(4'd11, 2), 2);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_result", result, 0);
    rst_n = 1'b1;

    run(4'd11, 0, 5, 11, 0, 4, "t11");
    run(4'd8,  0, EARLY ? 2 : 5, 8, 0, EARLY ? 1 : 4, "t8");
    run(4'd0,  0, 5, 0, 0, 4, "t0");
    run(4'd15, 0, 5, 15, 0, 4, "t15");
    run(4'd11, 2, 3, 0, 1, 2, "inj2");
    run(4'd3,  0, 5, 3, 0, 4, "t3");

    // Reset in cycle 2 of a search aborts it.
    wait_ready();
    @(negedge clk); target = 4'd6; inj = 0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1); chk("abort_pv", probe_valid, 0);
    chk("abort_probe", probe, 0); chk("abort_done", done, 0);
    chk("abort_result", result, 0); chk("abort_steps", steps, 0);
    dn = 0;
    repeat (8) begin @(negedge clk); if (done) dn++; end
    chk("abort_no_done", dn, 0);
    rst_n = 1'b1;
    run(4'd9, 0, 5, 9, 0, 4, "after_abort");

    // Start held high: back-to-back searches every WIDTH+2 cycles.
    wait_ready();
    @(negedge clk); target = 4'd5; inj = 0; start = 1'b1;
    dn = 0;
    repeat (18) begin @(negedge clk); if (done) dn++; end
    start = 1'b0;
    chk("held_start_dones", dn, 3);
    @(negedge clk);
    chk("held_start_result", result, 5);
    chk("held_start_ready", ready, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
